// File: rtl/max11046_pkg.sv
// rtl/max11046_pkg.sv - shared types, constants and output-format helper for the MAX11046 responder model
package max11046_pkg;

    typedef enum logic [1:0] {
        ST_SHDN    = 2'd0,
        ST_WAKE    = 2'd1,
        ST_IDLE    = 2'd2,
        ST_CONVERT = 2'd3
    } adc_state_t;

    localparam int CFG_OFFSET_BIN = 0;
    localparam int DEF_NUM_CH     = 8;
    localparam int DEF_DATA_W     = 16;

    // Offset binary is two's complement with the sign bit flipped, so the format
    // reduces to whether the MSB of the sample gets inverted.
    function automatic logic fmt_msb_flip(input logic [7:0] cfg);
        return cfg[CFG_OFFSET_BIN];
    endfunction

endpackage

// File: rtl/max11046_pin_sync.sv
// rtl/max11046_pin_sync.sv - 2-flop synchronizer plus edge flop producing level, rise and fall pulses
module max11046_pin_sync #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clock1,
    input  logic switch_rst,
    input  logic pin,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [2:0] sync_q;

    always_ff @(posedge clock1) begin
        if (switch_rst) begin
            sync_q <= {3{RST_VAL}};
        end else begin
            sync_q <= {sync_q[1:0], pin};
        end
    end

    assign level = sync_q[1];
    assign rise  = sync_q[1] & ~sync_q[2];
    assign fall  = ~sync_q[1] & sync_q[2];

endmodule

// File: rtl/max11046_adc_model.sv
// rtl/max11046_adc_model.sv - responder model of the MAX11046 parallel ADC: conversion timing, readback and config
module max11046_adc_model
    import max11046_pkg::*;
#(
    parameter int NUM_CH      = DEF_NUM_CH,
    parameter int DATA_W      = DEF_DATA_W,
    parameter int CONV_CYCLES = 150,
    parameter int WAKE_CYCLES = 64
) (
    input  logic                     clock1,
    input  logic                     switch_rst,
    input  logic                     conv_start,
    input  logic                     chip_sel,
    input  logic                     write,
    input  logic                     read_s,
    input  logic                     shutd,
    input  logic [NUM_CH*DATA_W-1:0] ch_data,
    input  logic [DATA_W-1:0]        db_in,
    output logic                     end_of_con,
    output logic [DATA_W-1:0]        db_out,
    output logic                     db_oe,
    output logic                     overrun
);

    localparam int CNT_MAX = (CONV_CYCLES > WAKE_CYCLES) ? CONV_CYCLES : WAKE_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int PTR_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    logic conv_lvl, conv_rise, unused_conv_fall;
    logic cs_lvl, cs_rise, unused_cs_fall;
    logic wr_lvl, wr_rise, unused_wr_fall, unused_wr_lvl;
    logic rd_lvl, rd_rise, rd_fall;
    logic shdn_lvl, unused_shdn_rise, unused_shdn_fall;
    logic unused_db_hi;

    max11046_pin_sync #(.RST_VAL(1'b0)) u_sync_conv (
        .clock1(clock1), .switch_rst(switch_rst), .pin(conv_start),
        .level(conv_lvl), .rise(conv_rise), .fall(unused_conv_fall));
    max11046_pin_sync #(.RST_VAL(1'b1)) u_sync_cs (
        .clock1(clock1), .switch_rst(switch_rst), .pin(chip_sel),
        .level(cs_lvl), .rise(cs_rise), .fall(unused_cs_fall));
    max11046_pin_sync #(.RST_VAL(1'b1)) u_sync_wr (
        .clock1(clock1), .switch_rst(switch_rst), .pin(write),
        .level(wr_lvl), .rise(wr_rise), .fall(unused_wr_fall));
    max11046_pin_sync #(.RST_VAL(1'b1)) u_sync_rd (
        .clock1(clock1), .switch_rst(switch_rst), .pin(read_s),
        .level(rd_lvl), .rise(rd_rise), .fall(rd_fall));
    // Resets low so a held-high SHDN pin walks through the wake delay after reset.
    max11046_pin_sync #(.RST_VAL(1'b0)) u_sync_shdn (
        .clock1(clock1), .switch_rst(switch_rst), .pin(shutd),
        .level(shdn_lvl), .rise(unused_shdn_rise), .fall(unused_shdn_fall));

    assign unused_wr_lvl = wr_lvl ^ conv_lvl;
    assign unused_db_hi  = ^db_in[DATA_W-1:8];

    adc_state_t                state_q, state_d;
    logic [CNT_W-1:0]          cnt_q, cnt_d;
    logic                      start_conv, conv_done, overrun_set;
    logic [NUM_CH*DATA_W-1:0]  hold_buf, read_buf;
    logic [PTR_W-1:0]          ch_ptr;
    logic [7:0]                cfg;
    logic                      data_ready;
    logic [DATA_W-1:0]         msb_mask, rd_word, hold_ch0;

    assign msb_mask = {fmt_msb_flip(cfg), {(DATA_W-1){1'b0}}};
    assign rd_word  = read_buf[int'(ch_ptr)*DATA_W +: DATA_W];
    assign hold_ch0 = hold_buf[DATA_W-1:0];

    always_ff @(posedge clock1) begin
        if (switch_rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        start_conv  = 1'b0;
        conv_done   = 1'b0;
        overrun_set = 1'b0;
        if (!shdn_lvl) begin
            state_d = ST_SHDN;
        end else begin
            case (state_q)
                ST_SHDN: begin
                    state_d = ST_WAKE;
                    cnt_d   = CNT_W'(WAKE_CYCLES);
                end
                ST_WAKE: begin
                    if (cnt_q <= CNT_W'(1)) state_d = ST_IDLE;
                    else                    cnt_d   = cnt_q - CNT_W'(1);
                end
                ST_IDLE: begin
                    if (conv_rise) begin
                        start_conv = 1'b1;
                        state_d    = ST_CONVERT;
                        cnt_d      = CNT_W'(CONV_CYCLES);
                    end
                end
                ST_CONVERT: begin
                    overrun_set = conv_rise;
                    if (cnt_q == CNT_W'(1)) begin
                        conv_done = 1'b1;
                        state_d   = ST_IDLE;
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clock1) begin
        if (switch_rst) begin
            hold_buf   <= '0;
            read_buf   <= '0;
            ch_ptr     <= '0;
            cfg        <= '0;
            data_ready <= 1'b0;
            end_of_con <= 1'b1;
            db_out     <= '0;
            db_oe      <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            if (start_conv) hold_buf <= ch_data;
            if (conv_done) begin
                read_buf   <= hold_buf;
                data_ready <= 1'b1;
                end_of_con <= 1'b0;
            end
            if (overrun_set) overrun <= 1'b1;

            if (!shdn_lvl) begin
                end_of_con <= 1'b1;
                db_oe      <= 1'b0;
                data_ready <= 1'b0;
            end else if (cs_rise) begin
                db_oe  <= 1'b0;
                ch_ptr <= '0;
            end else if (!cs_lvl) begin
                if (rd_fall) begin
                    db_oe <= 1'b1;
                    // A read landing on the completion cycle sees the fresh channel 0.
                    if (conv_done) begin
                        db_out     <= hold_ch0 ^ msb_mask;
                        end_of_con <= 1'b1;
                    end else if (data_ready) begin
                        db_out     <= rd_word ^ msb_mask;
                        end_of_con <= 1'b1;
                    end else begin
                        db_out  <= '0;
                        overrun <= 1'b1;
                    end
                end else if (rd_rise) begin
                    db_oe  <= 1'b0;
                    ch_ptr <= (ch_ptr == PTR_W'(NUM_CH-1)) ? '0 : ch_ptr + 1'b1;
                end
                if (wr_rise && rd_lvl) cfg <= db_in[7:0];
            end

            if (conv_done) ch_ptr <= '0;
        end
    end

endmodule
